// File: rtl/copier_pkg.sv
// Shared constants and state encoding for the copier local I/O initiator.
package copier_pkg;
  localparam int COPIER_ADDR_W = 6;
  localparam int COPIER_DATA_W = 32;
  localparam int COPIER_LEN_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } copier_state_e;
endpackage

// File: rtl/copier_io_initiator.sv
// Block-copy initiator on the local I/O queue: for each word it reads src+i and
// then writes dst+i, one request outstanding at a time.
module copier_io_initiator
  import copier_pkg::*;
#(
  parameter int ADDR_W = COPIER_ADDR_W,
  parameter int DATA_W = COPIER_DATA_W,
  parameter int LEN_W  = COPIER_LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              finished,
  output logic [LEN_W-1:0]  count,
  output logic [ADDR_W-1:0] aq,
  output logic              read,
  output logic [DATA_W-1:0] wq,
  output logic              sel,
  input  logic [DATA_W-1:0] rq,
  input  logic              wrq,
  input  logic              rwq,
  input  logic              done
);

  copier_state_e     state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, aq_q, aq_d;
  logic [LEN_W-1:0]  len_q, len_d, count_q, count_d, count_inc;
  logic [DATA_W-1:0] wq_q, wq_d;
  logic              read_q, read_d, sel_q, sel_d;
  logic              busy_q, busy_d, finished_q, finished_d;
  logic              abort_q, abort_d;

  // The FSM advances on done alone; the data strobes carry no extra information.
  logic unused_advisory;
  assign unused_advisory = wrq ^ rwq;

  assign count_inc = count_q + LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    count_d    = count_q;
    aq_d       = aq_q;
    read_d     = read_q;
    wq_d       = wq_q;
    sel_d      = sel_q;
    finished_d = 1'b0;
    abort_d    = abort_q;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          if (length != '0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = length;
            count_d = '0;
            aq_d    = src_addr;
            read_d  = 1'b1;
            sel_d   = 1'b1;
            state_d = ST_RD;
          end else begin
            finished_d = 1'b1;
          end
        end
      end
      ST_RD: begin
        // A stop request seen mid-word is held until the word's write completes.
        if (abort) abort_d = 1'b1;
        if (done) begin
          wq_d    = rq;
          aq_d    = dst_q + ADDR_W'(count_q);
          read_d  = 1'b0;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (done) begin
          count_d = count_inc;
          if (count_inc == len_q || abort || abort_q) begin
            sel_d      = 1'b0;
            abort_d    = 1'b0;
            finished_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            aq_d    = src_q + ADDR_W'(count_inc);
            read_d  = 1'b1;
            state_d = ST_RD;
          end
        end else if (abort) begin
          abort_d = 1'b1;
        end
      end
      default: begin
        sel_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      count_q    <= '0;
      aq_q       <= '0;
      read_q     <= 1'b0;
      wq_q       <= '0;
      sel_q      <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      count_q    <= count_d;
      aq_q       <= aq_d;
      read_q     <= read_d;
      wq_q       <= wq_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      abort_q    <= abort_d;
    end
  end

  assign busy     = busy_q;
  assign finished = finished_q;
  assign count    = count_q;
  assign aq       = aq_q;
  assign read     = read_q;
  assign wq       = wq_q;
  assign sel      = sel_q;

endmodule

// File: tb/tb_copier_io_initiator.sv
// Bench for copier_io_initiator: 64x32 RAM responder, table of copy commands,
// randomized commands against an array-level copy model, plus reset/abort sequences.
module tb_copier_io_initiator;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int LW = 7;
  localparam int NW = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [LW-1:0] length = '0;
  logic          abort = 1'b0;
  logic          busy, finished, read, sel;
  logic [LW-1:0] count;
  logic [AW-1:0] aq;
  logic [DW-1:0] wq, rq;
  logic          wrq, rwq, done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem     [NW];
  logic [DW-1:0] ref_mem [NW];

  copier_io_initiator #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .abort(abort), .busy(busy),
    .finished(finished), .count(count), .aq(aq), .read(read), .wq(wq),
    .sel(sel), .rq(rq), .wrq(wrq), .rwq(rwq), .done(done)
  );

  always #5 clock = ~clock;

  // Responder: done one cycle after sel, then one idle cycle before re-arming.
  always @(posedge clock or posedge reset)
    if (reset) done <= 1'b0;
    else       done <= sel & ~done;

  always @(posedge clock)
    if (!reset && sel && done && !read) mem[aq] = wq;

  assign rq  = mem[aq];
  assign wrq = done & read;
  assign rwq = done & ~read;

  // Request stability: nothing may change while a request is pending.
  logic          p_valid = 1'b0, p_sel = 1'b0, p_done = 1'b0, p_read = 1'b0;
  logic [AW-1:0] p_aq = '0;
  logic [DW-1:0] p_wq = '0;
  always @(negedge clock) begin
    if (reset) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && p_sel && !p_done) begin
        checks++;
        if (!(sel && aq == p_aq && read == p_read && wq == p_wq)) begin
          errors++;
          $display("FAIL req_stable: sel=%0b aq=%0d read=%0b wq=%h, required sel=1 aq=%0d read=%0b wq=%h",
                   sel, aq, read, wq, p_aq, p_read, p_wq);
        end
      end
      p_valid = 1'b1; p_sel = sel; p_done = done; p_read = read; p_aq = aq; p_wq = wq;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ram(input string name);
    int bad = 0, first = -1;
    for (int i = 0; i < NW; i++)
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d words differ, first at %0d got %h expected %h",
               name, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  // Reference copy: forward, word by word, addresses modulo the RAM size.
  task automatic ref_copy(input int s, input int d, input int n);
    for (int i = 0; i < n; i++) ref_mem[(d + i) % NW] = ref_mem[(s + i) % NW];
  endtask

  task automatic init_mem(input bit rnd);
    for (int i = 0; i < NW; i++) begin
      mem[i]     = rnd ? $urandom : DW'(i * 3);
      ref_mem[i] = mem[i];
    end
  endtask

  // Called #1 after a posedge with the DUT idle; returns the cycle finished appeared.
  task automatic run_cmd(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                         input int ab_cyc, input int bs_cyc,
                         output int fin, output bit saw_busy, output bit saw_sel, output bit busy1);
    fin = -1; saw_busy = 0; saw_sel = 0; busy1 = 0;
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    src_addr = ~s; dst_addr = ~d; length = LW'(5);
    for (int c = 1; c < 2000; c++) begin
      abort = (c == ab_cyc);
      start = (c == bs_cyc);
      if (c == 1) busy1 = busy;
      if (busy) saw_busy = 1;
      if (sel) saw_sel = 1;
      if (finished) begin
        fin = c;
        break;
      end
      @(posedge clock); #1;
    end
    abort = 1'b0; start = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] s, d;
    logic [LW-1:0] n;
    int ab, bs, exp_w, exp_fin;
  } vec_t;

  task automatic apply(input string name, input vec_t v, input bit rnd);
    int fin; bit sb, ss, b1;
    init_mem(rnd);
    ref_copy(v.s, v.d, v.exp_w);
    run_cmd(v.s, v.d, v.n, v.ab, v.bs, fin, sb, ss, b1);
    chk({name, ".finish_cycle"}, fin, v.exp_fin);
    if (v.n != 0) begin
      chk({name, ".busy_c1"}, b1, 1);
      chk({name, ".count"}, count, v.exp_w);
    end else begin
      chk({name, ".busy_seen"}, sb, 0);
      chk({name, ".sel_seen"}, ss, 0);
    end
    chk({name, ".busy_at_fin"}, busy, 0);
    repeat (3) @(posedge clock); #1;
    chk({name, ".idle_after"}, {busy, sel, finished}, 0);
    chk_ram({name, ".ram"});
  endtask

  vec_t vecs [7];

  initial begin
    int fin; bit sb, ss, b1;
    vec_t rv;

    vecs[0] = '{s: 0,  d: 32, n: 4,   ab: -1, bs: -1, exp_w: 4,   exp_fin: 17};
    vecs[1] = '{s: 3,  d: 4,  n: 0,   ab: -1, bs: -1, exp_w: 0,   exp_fin: 1};
    vecs[2] = '{s: 62, d: 10, n: 4,   ab: -1, bs: -1, exp_w: 4,   exp_fin: 17};
    vecs[3] = '{s: 8,  d: 40, n: 8,   ab: 5,  bs: -1, exp_w: 2,   exp_fin: 9};
    vecs[4] = '{s: 16, d: 48, n: 6,   ab: -1, bs: 3,  exp_w: 6,   exp_fin: 25};
    vecs[5] = '{s: 5,  d: 6,  n: 3,   ab: -1, bs: -1, exp_w: 3,   exp_fin: 13};
    vecs[6] = '{s: 1,  d: 0,  n: 127, ab: -1, bs: -1, exp_w: 127, exp_fin: 509};

    init_mem(0);
    #1;
    chk("reset.outputs", {busy, finished, sel, read, count, aq, wq}, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    chk("post_reset.outputs", {busy, finished, sel, read, count, aq}, 0);

    for (int i = 0; i < 7; i++) begin
      apply($sformatf("vec%0d", i), vecs[i], 0);
      if (i == 0) chk("vec0.ram35", int'(mem[35]), 9);
    end

    // abort while idle must not leak into the next command
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    apply("idle_abort", '{s: 20, d: 30, n: 3, ab: -1, bs: -1, exp_w: 3, exp_fin: 13}, 1);

    // reset in the middle of the first write
    init_mem(1);
    src_addr = 0; dst_addr = 20; length = 8; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("midwr.read_low", read, 0);
    reset = 1'b1;
    #1;
    chk("midwr.sel", sel, 0);
    chk("midwr.busy", busy, 0);
    @(posedge clock); #1;
    chk("midwr.finished", finished, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk_ram("midwr.ram_untouched");
    run_cmd(AW'(2), AW'(50), LW'(5), -1, -1, fin, sb, ss, b1);
    ref_copy(2, 50, 5);
    chk("after_reset.finish_cycle", fin, 21);
    chk("after_reset.count", count, 5);
    chk_ram("after_reset.ram");

    // randomized commands, some with an abort at a random cycle
    for (int k = 0; k < 10; k++) begin
      int n, ab, w;
      n  = $urandom_range(1, 20);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4 * n) : -1;
      w  = (ab < 0) ? n : (((ab - 1) / 4 + 1) < n ? ((ab - 1) / 4 + 1) : n);
      rv = '{s: AW'($urandom), d: AW'($urandom), n: LW'(n), ab: ab, bs: -1,
             exp_w: w, exp_fin: 4 * w + 1};
      apply($sformatf("rnd%0d", k), rv, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
